// File: rtl/ppc_multimode_counter.sv
`default_nettype none
// ============================================================================
//  Module   : ppc_multimode_counter
//  Brief    : Parameterised step counter with ping-pong / wrap / one-shot
//             boundary handling, synchronous load and saturating bounce count.
//  Revision : 1.0 - initial release
// ============================================================================
module ppc_multimode_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             flip,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] step,
    input  logic [WIDTH-1:0] max,
    input  logic [WIDTH-1:0] min,
    output logic             direction,
    output logic [WIDTH-1:0] out,
    output logic             hold,
    output logic             done,
    output logic             bounce,
    output logic [CNT_W-1:0] bounce_cnt
);

    localparam logic [1:0] c_init         = 2'd0;
    localparam logic [1:0] c_run          = 2'd1;
    localparam logic [1:0] c_done         = 2'd2;
    localparam logic [1:0] c_mode_wrap    = 2'd1;
    localparam logic [1:0] c_mode_oneshot = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_out;
    logic             r_dir;
    logic             r_done;
    logic             r_bounce;
    logic [CNT_W-1:0] r_bcnt;

    logic             w_range_bad;
    logic [WIDTH:0]   w_step;
    logic [WIDTH:0]   w_up_sum;
    logic [WIDTH:0]   w_dn_lim;
    logic [WIDTH-1:0] w_up_val;
    logic [WIDTH-1:0] w_dn_val;
    logic             w_d;
    logic             w_at_bound;
    logic [CNT_W-1:0] w_bcnt_inc;

    logic [1:0]       w_nxt_state;
    logic [WIDTH-1:0] w_nxt_out;
    logic             w_nxt_dir;
    logic             w_nxt_done;
    logic             w_nxt_bounce;
    logic [CNT_W-1:0] w_nxt_bcnt;

    assign w_range_bad = (max <= min) | (r_out < min) | (r_out > max);
    assign hold        = (r_state != c_init) & w_range_bad;

    // One extra bit keeps the clamp comparisons free of wraparound.
    assign w_step   = (step == '0) ? (WIDTH+1)'(1) : {1'b0, step};
    assign w_up_sum = {1'b0, r_out} + w_step;
    assign w_dn_lim = {1'b0, min} + w_step;
    assign w_up_val = (w_up_sum > {1'b0, max}) ? max : w_up_sum[WIDTH-1:0];
    assign w_dn_val = ({1'b0, r_out} >= w_dn_lim) ? (r_out - w_step[WIDTH-1:0]) : min;

    assign w_d        = r_dir ^ flip;
    assign w_at_bound = w_d ? (r_out == max) : (r_out == min);
    assign w_bcnt_inc = (r_bcnt == '1) ? r_bcnt : (r_bcnt + CNT_W'(1));

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_out    = r_out;
        w_nxt_dir    = r_dir;
        w_nxt_done   = r_done;
        w_nxt_bounce = 1'b0;
        w_nxt_bcnt   = r_bcnt;
        if (r_state == c_init) begin
            w_nxt_out   = min;
            w_nxt_dir   = 1'b1;
            w_nxt_state = c_run;
        end else if (load) begin
            w_nxt_out   = load_val;
            w_nxt_dir   = 1'b1;
            w_nxt_done  = 1'b0;
            w_nxt_bcnt  = '0;
            w_nxt_state = c_run;
        end else if (enable && (r_state != c_done) && !w_range_bad) begin
            if (w_at_bound) begin
                if (mode == c_mode_oneshot) begin
                    w_nxt_dir   = w_d;
                    w_nxt_done  = 1'b1;
                    w_nxt_state = c_done;
                end else if (mode == c_mode_wrap) begin
                    w_nxt_out    = w_d ? min : max;
                    w_nxt_dir    = w_d;
                    w_nxt_bounce = 1'b1;
                    w_nxt_bcnt   = w_bcnt_inc;
                end else begin
                    // Ping-pong: reverse first, then take a step the other way.
                    w_nxt_out    = w_d ? w_dn_val : w_up_val;
                    w_nxt_dir    = ~w_d;
                    w_nxt_bounce = 1'b1;
                    w_nxt_bcnt   = w_bcnt_inc;
                end
            end else begin
                w_nxt_out = w_d ? w_up_val : w_dn_val;
                w_nxt_dir = w_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_init;
            r_out    <= '0;
            r_dir    <= 1'b1;
            r_done   <= 1'b0;
            r_bounce <= 1'b0;
            r_bcnt   <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_out    <= w_nxt_out;
            r_dir    <= w_nxt_dir;
            r_done   <= w_nxt_done;
            r_bounce <= w_nxt_bounce;
            r_bcnt   <= w_nxt_bcnt;
        end
    end

    assign out        = r_out;
    assign direction  = r_dir;
    assign done       = r_done;
    assign bounce     = r_bounce;
    assign bounce_cnt = r_bcnt;

endmodule
`default_nettype wire

// File: tb/tb_ppc_multimode_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ppc_multimode_counter
//  Brief    : Scoreboard bench for ppc_multimode_counter against an
//             arithmetic reference model, directed and random stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ppc_multimode_counter;

    localparam int W    = 4;
    localparam int CW   = 3;
    localparam int BMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic          flip = 1'b0;
    logic          load = 1'b0;
    logic [W-1:0]  load_val = '0;
    logic [1:0]    mode = 2'd0;
    logic [W-1:0]  step_v = 4'd1;
    logic [W-1:0]  max_v = '0;
    logic [W-1:0]  min_v = '0;
    logic          direction;
    logic [W-1:0]  out;
    logic          hold;
    logic          done;
    logic          bounce;
    logic [CW-1:0] bounce_cnt;

    ppc_multimode_counter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .flip(flip), .load(load),
        .load_val(load_val), .mode(mode), .step(step_v), .max(max_v), .min(min_v),
        .direction(direction), .out(out), .hold(hold), .done(done),
        .bounce(bounce), .bounce_cnt(bounce_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int out; int dir; int done; int bounce; int bcnt; int hold;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_on = 1'b0;

    // Reference model state, in plain integers
    int m_out, m_bcnt;
    bit m_dir, m_fin, m_run, m_bounce;

    function automatic bit m_range_bad();
        return (int'(max_v) <= int'(min_v)) || (m_out < int'(min_v)) || (m_out > int'(max_v));
    endfunction

    function automatic int clamp_step(bit up, int s);
        int lo = int'(min_v);
        int hi = int'(max_v);
        if (up) return (m_out + s > hi) ? hi : m_out + s;
        return (m_out - s < lo) ? lo : m_out - s;
    endfunction

    function automatic void model_reset();
        m_out = 0; m_dir = 1'b1; m_fin = 1'b0; m_bcnt = 0; m_bounce = 1'b0; m_run = 1'b0;
    endfunction

    function automatic void model_edge();
        int s;
        bit d, at;
        m_bounce = 1'b0;
        if (!m_run) begin
            m_out = int'(min_v); m_dir = 1'b1; m_run = 1'b1;
            return;
        end
        if (load) begin
            m_out = int'(load_val); m_dir = 1'b1; m_fin = 1'b0; m_bcnt = 0;
            return;
        end
        if (!enable || m_fin || m_range_bad()) return;
        s  = (step_v == 0) ? 1 : int'(step_v);
        d  = m_dir ^ flip;
        at = d ? (m_out == int'(max_v)) : (m_out == int'(min_v));
        if (at && mode == 2'd2) begin
            m_fin = 1'b1; m_dir = d;
            return;
        end
        if (at) begin
            m_bounce = 1'b1;
            m_bcnt   = (m_bcnt < BMAX) ? m_bcnt + 1 : BMAX;
        end
        if (at && mode == 2'd1) begin
            m_out = d ? int'(min_v) : int'(max_v);
        end else begin
            if (at) d = !d;
            m_out = clamp_step(d, s);
        end
        m_dir = d;
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.out = m_out; e.dir = int'(m_dir); e.done = int'(m_fin);
        e.bounce = int'(m_bounce); e.bcnt = m_bcnt;
        e.hold = int'(m_run && m_range_bad());
        q.push_back(e);
    endfunction

    // Called just after a falling edge with inputs already settled
    task automatic tick();
        if (!rst_n) model_reset(); else model_edge();
        push_exp();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic async_reset();
        #2;
        model_reset();
        push_exp();
        rst_n = 1'b0;
        ticks(2);
        rst_n = 1'b1;
    endtask

    task automatic set_range(input int md, input int mn, input int mx, input int st);
        mode = 2'(md); min_v = W'(mn); max_v = W'(mx); step_v = W'(st);
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = W'(v);
        tick();
        load = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares on every clock edge and on asynchronous reset entry
    initial begin
        exp_t e;
        wait (mon_on);
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (mon_on) begin
                if (q.size() == 0) begin
                    chk("queue_underflow", 32'd1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out",        32'(out),        e.out);
                    chk("direction",  32'(direction),  e.dir);
                    chk("done",       32'(done),       e.done);
                    chk("bounce",     32'(bounce),     e.bounce);
                    chk("bounce_cnt", 32'(bounce_cnt), e.bcnt);
                    chk("hold",       32'(hold),       e.hold);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, lo;
        model_reset();
        set_range(0, 0, 4, 1);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        mon_on = 1'b1;
        tick();
        rst_n = 1'b1;

        // Ping-pong 0..4, then 3..10 step 3, then step 0
        ticks(12);
        set_range(0, 3, 10, 3);
        do_load(3);
        ticks(8);
        step_v = '0;
        ticks(6);
        // Saturating bounce count on a two-value range
        set_range(0, 0, 1, 1);
        do_load(0);
        ticks(12);
        // Wrap 2..5 with a flip mid-run
        set_range(1, 2, 5, 1);
        do_load(2);
        ticks(5);
        flip = 1'b1; tick(); flip = 1'b0;
        ticks(4);
        // One-shot 0..3, reload, finish again
        set_range(2, 0, 3, 1);
        do_load(0);
        ticks(6);
        do_load(1);
        ticks(4);
        // Invalid ranges freeze the count
        set_range(0, 9, 9, 1);
        ticks(3);
        set_range(0, 10, 5, 1);
        ticks(3);
        set_range(0, 0, 15, 2);
        ticks(4);
        enable = 1'b0; flip = 1'b1; ticks(3);
        enable = 1'b1; flip = 1'b0;
        ticks(3);
        async_reset();
        ticks(4);

        // Randomised phase
        for (int c = 0; c < 1500; c++) begin
            if (c % 40 == 0) mode = 2'($urandom_range(0, 3));
            if (c % 25 == 0) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    min_v = W'($urandom_range(0, 15)); max_v = min_v;
                end else if (r == 1) begin
                    min_v = W'($urandom_range(8, 15)); max_v = W'($urandom_range(0, 7));
                end else begin
                    lo = $urandom_range(0, 7);
                    min_v = W'(lo); max_v = W'($urandom_range(lo + 1, 15));
                end
            end
            step_v   = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 15)) : W'($urandom_range(0, 3));
            enable   = ($urandom_range(0, 7) != 0);
            flip     = ($urandom_range(0, 9) == 0);
            load     = ($urandom_range(0, 29) == 0);
            load_val = W'($urandom_range(0, 15));
            if (c % 500 == 499) async_reset(); else tick();
        end

        mon_on = 1'b0;
        if (q.size() != 0) chk("queue_drain", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
